// File: rtl/sd_route_ctrl.sv
// SD card SPI router: steers each chip select to a mounted virtual image or to the
// physical card (slot 0), tracks SPI activity and issues a reset request on mount.
module sd_route_ctrl #(
    parameter int NUM_IMG       = 2,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter int MOUNT_RST_CYC = 16
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_IMG-1:0] img_mounted,
    input  logic [NUM_IMG-1:0] img_size_nz,
    input  logic               mount_rst_en,
    input  logic [NUM_IMG-1:0] cs_n_i,
    input  logic               sck_i,
    input  logic               mosi_i,
    output logic               miso_o,
    output logic [NUM_IMG-1:0] vsd_ss_n_o,
    input  logic [NUM_IMG-1:0] vsd_miso_i,
    output logic               sd_cs_n_o,
    output logic               sd_sck_o,
    output logic               sd_mosi_o,
    input  logic               sd_miso_i,
    output logic [NUM_IMG-1:0] vsd_sel_o,
    output logic               active_o,
    output logic               reset_req_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = $clog2(MOUNT_RST_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MOUNT_RST_CYC);

    typedef enum logic [0:0] {IDLE, PULSE} state_t;

    logic [NUM_IMG-1:0] mnt_p1;
    logic [NUM_IMG-1:0] rise;
    logic [NUM_IMG-1:0] vsd_sel;
    logic               miso_sel;
    logic               mosi_p1;
    logic               miso_p1;
    logic               toggle;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nxt;
    logic               active_q;
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               mnt_go;
    logic               reset_req_q;

    assign rise   = img_mounted & ~mnt_p1;
    assign mnt_go = (|rise) & mount_rst_en;

    // Stage p1: mount edge detect and routing select
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mnt_p1  <= '0;
            vsd_sel <= '0;
        end else begin
            mnt_p1  <= img_mounted;
            vsd_sel <= (vsd_sel & ~rise) | (img_size_nz & rise);
        end
    end

    assign vsd_ss_n_o = cs_n_i | ~vsd_sel;
    assign sd_cs_n_o  = cs_n_i[0] | vsd_sel[0];
    assign sd_sck_o   = sck_i & ~vsd_sel[0];
    assign sd_mosi_o  = mosi_i & ~vsd_sel[0];
    assign vsd_sel_o  = vsd_sel;

    // Iterating downward lets the lowest asserted select override the others.
    always_comb begin
        miso_sel = 1'b1;
        for (int i = NUM_IMG - 1; i >= 0; i--) begin
            if (!cs_n_i[i]) begin
                if (vsd_sel[i])
                    miso_sel = vsd_miso_i[i];
                else if (i == 0)
                    miso_sel = sd_miso_i;
                else
                    miso_sel = 1'b1;
            end
        end
    end

    assign miso_o = miso_sel;

    assign toggle = (mosi_i ^ mosi_p1) | (miso_sel ^ miso_p1);

    always_comb begin
        timer_nxt = timer;
        if (toggle)
            timer_nxt = '0;
        else if (timer < TMR_MAX)
            timer_nxt = timer + TMR_W'(1);
    end

    // Stage p1: activity timer; the flag looks at the next timer value so it
    // drops exactly TIMEOUT_CYC edges after the toggle edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mosi_p1  <= 1'b0;
            miso_p1  <= 1'b1;
            timer    <= TMR_MAX;
            active_q <= 1'b0;
        end else begin
            mosi_p1  <= mosi_i;
            miso_p1  <= miso_sel;
            timer    <= timer_nxt;
            active_q <= (timer_nxt < TMR_MAX);
        end
    end

    assign active_o = active_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mnt_go) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            PULSE: begin
                if (mnt_go) begin
                    cnt_nxt = CNT_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stage p1: mount reset pulse
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            reset_req_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            reset_req_q <= (state_nxt == PULSE);
        end
    end

    assign reset_req_o = reset_req_q;

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Directed bench for sd_route_ctrl: routing, activity timeout, mount reset pulse.
module tb_sd_route_ctrl;

    localparam int NUM_IMG = 2;

    logic               clk_sys;
    logic               reset_n;
    logic [NUM_IMG-1:0] img_mounted;
    logic [NUM_IMG-1:0] img_size_nz;
    logic               mount_rst_en;
    logic [NUM_IMG-1:0] cs_n_i;
    logic               sck_i;
    logic               mosi_i;
    logic               miso_o;
    logic [NUM_IMG-1:0] vsd_ss_n_o;
    logic [NUM_IMG-1:0] vsd_miso_i;
    logic               sd_cs_n_o;
    logic               sd_sck_o;
    logic               sd_mosi_o;
    logic               sd_miso_i;
    logic [NUM_IMG-1:0] vsd_sel_o;
    logic               active_o;
    logic               reset_req_o;

    int errors = 0;
    int checks = 0;

    sd_route_ctrl #(
        .NUM_IMG       (NUM_IMG),
        .TIMEOUT_CYC   (8),
        .MOUNT_RST_CYC (4)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_size_nz  (img_size_nz),
        .mount_rst_en (mount_rst_en),
        .cs_n_i       (cs_n_i),
        .sck_i        (sck_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .vsd_ss_n_o   (vsd_ss_n_o),
        .vsd_miso_i   (vsd_miso_i),
        .sd_cs_n_o    (sd_cs_n_o),
        .sd_sck_o     (sd_sck_o),
        .sd_mosi_o    (sd_mosi_o),
        .sd_miso_i    (sd_miso_i),
        .vsd_sel_o    (vsd_sel_o),
        .active_o     (active_o),
        .reset_req_o  (reset_req_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        img_mounted  = 2'b00;
        img_size_nz  = 2'b00;
        mount_rst_en = 1'b0;
        cs_n_i       = 2'b11;
        sck_i        = 1'b0;
        mosi_i       = 1'b0;
        vsd_miso_i   = 2'b11;
        sd_miso_i    = 1'b1;
        step(2);
        chk("rst_vsd_sel", vsd_sel_o, 2'b00);
        chk("rst_active", active_o, 1'b0);
        chk("rst_reset_req", reset_req_o, 1'b0);
        chk("rst_miso_idle", miso_o, 1'b1);
        chk("rst_vsd_ss_n", vsd_ss_n_o, 2'b11);
        chk("rst_sd_cs_n", sd_cs_n_o, 1'b1);

        reset_n = 1'b1;
        step(3);
        chk("idle_active", active_o, 1'b0);
        chk("idle_vsd_sel", vsd_sel_o, 2'b00);

        // Physical card on slot 0
        cs_n_i    = 2'b10;
        sd_miso_i = 1'b0;
        sck_i     = 1'b1;
        #1;
        chk("phys_miso", miso_o, 1'b0);
        chk("phys_cs_n", sd_cs_n_o, 1'b0);
        chk("phys_vsd_ss_n", vsd_ss_n_o, 2'b11);
        chk("phys_sck", sd_sck_o, 1'b1);
        chk("phys_mosi", sd_mosi_o, 1'b0);

        // miso_o toggled 1->0: activity rises, falls 8 edges later
        step(1);
        chk("act_miso_e0", active_o, 1'b1);
        step(7);
        chk("act_miso_e7", active_o, 1'b1);
        step(1);
        chk("act_miso_e8", active_o, 1'b0);

        // mosi toggle, retoggle at +7 keeps activity alive
        mosi_i = 1'b1;
        #1;
        chk("phys_mosi_hi", sd_mosi_o, 1'b1);
        step(1);
        chk("act_mosi_m0", active_o, 1'b1);
        step(6);
        mosi_i = 1'b0;
        step(1);
        chk("act_mosi_m7", active_o, 1'b1);
        step(1);
        chk("act_mosi_m8_kept", active_o, 1'b1);
        step(6);
        chk("act_mosi_r7", active_o, 1'b1);
        step(1);
        chk("act_mosi_r8", active_o, 1'b0);

        // Mount slot 0 mid-transfer, reset request disabled
        sd_miso_i   = 1'b1;
        img_size_nz = 2'b01;
        img_mounted = 2'b01;
        mosi_i      = 1'b1;
        vsd_miso_i  = 2'b10;
        #1;
        chk("mnt0_latency_sel", vsd_sel_o, 2'b00);
        chk("mnt0_latency_cs", sd_cs_n_o, 1'b0);
        step(1);
        chk("mnt0_sel", vsd_sel_o, 2'b01);
        chk("mnt0_sd_cs_n", sd_cs_n_o, 1'b1);
        chk("mnt0_sd_sck", sd_sck_o, 1'b0);
        chk("mnt0_sd_mosi", sd_mosi_o, 1'b0);
        chk("mnt0_vsd_ss_n", vsd_ss_n_o, 2'b10);
        chk("mnt0_miso_v0", miso_o, 1'b0);
        chk("mnt0_no_rst_req", reset_req_o, 1'b0);
        vsd_miso_i = 2'b01;
        sd_miso_i  = 1'b0;
        #1;
        chk("mnt0_miso_v1", miso_o, 1'b1);

        // Both slots virtual, both selected: slot 0 wins
        img_size_nz = 2'b11;
        img_mounted = 2'b11;
        step(1);
        chk("mnt1_sel", vsd_sel_o, 2'b11);
        cs_n_i     = 2'b00;
        vsd_miso_i = 2'b10;
        sd_miso_i  = 1'b1;
        #1;
        chk("prio_miso", miso_o, 1'b0);
        chk("prio_vsd_ss_n", vsd_ss_n_o, 2'b00);

        // Slot 1 remounted empty, only its select asserted
        img_mounted = 2'b01;
        step(1);
        img_size_nz = 2'b01;
        img_mounted = 2'b11;
        step(1);
        chk("unmnt1_sel", vsd_sel_o, 2'b01);
        cs_n_i     = 2'b01;
        vsd_miso_i = 2'b00;
        sd_miso_i  = 1'b0;
        #1;
        chk("unmnt1_miso", miso_o, 1'b1);
        chk("unmnt1_vsd_ss_n", vsd_ss_n_o, 2'b11);
        chk("unmnt1_no_rst_req", reset_req_o, 1'b0);

        // Reset pulse extended by second rise two edges later
        img_mounted = 2'b00;
        step(1);
        mount_rst_en = 1'b1;
        img_mounted  = 2'b01;
        step(1);
        chk("ext_n0", reset_req_o, 1'b1);
        step(1);
        chk("ext_n1", reset_req_o, 1'b1);
        img_mounted = 2'b11;
        step(1);
        chk("ext_n2", reset_req_o, 1'b1);
        mount_rst_en = 1'b0;
        step(3);
        chk("ext_n5", reset_req_o, 1'b1);
        step(1);
        chk("ext_n6", reset_req_o, 1'b0);

        // Single pulse of exactly 4 cycles
        img_mounted  = 2'b00;
        mount_rst_en = 1'b1;
        step(1);
        img_mounted = 2'b10;
        step(1);
        chk("single_n0", reset_req_o, 1'b1);
        step(3);
        chk("single_n3", reset_req_o, 1'b1);
        step(1);
        chk("single_n4", reset_req_o, 1'b0);

        // Disabled: rise ignored
        img_mounted  = 2'b00;
        mount_rst_en = 1'b0;
        step(1);
        img_mounted = 2'b01;
        step(1);
        chk("dis_n0", reset_req_o, 1'b0);
        step(1);
        chk("dis_n1", reset_req_o, 1'b0);

        // Asynchronous reset during a pulse with slot 0 virtual
        img_mounted = 2'b00;
        step(1);
        mount_rst_en = 1'b1;
        img_size_nz  = 2'b01;
        cs_n_i       = 2'b10;
        sd_miso_i    = 1'b1;
        vsd_miso_i   = 2'b00;
        img_mounted  = 2'b01;
        step(1);
        chk("pre_rst_req", reset_req_o, 1'b1);
        chk("pre_rst_sel", vsd_sel_o, 2'b01);
        chk("pre_rst_miso", miso_o, 1'b0);
        reset_n      = 1'b0;
        img_mounted  = 2'b00;
        mount_rst_en = 1'b0;
        #1;
        chk("arst_req", reset_req_o, 1'b0);
        chk("arst_sel", vsd_sel_o, 2'b00);
        chk("arst_active", active_o, 1'b0);
        chk("arst_sd_cs_n", sd_cs_n_o, 1'b0);
        chk("arst_miso_phys", miso_o, 1'b1);
        chk("arst_vsd_ss_n", vsd_ss_n_o, 2'b11);
        step(2);
        reset_n = 1'b1;
        step(2);
        chk("post_rst_sd_cs_n", sd_cs_n_o, 1'b0);
        chk("post_rst_sel", vsd_sel_o, 2'b00);
        chk("post_rst_req", reset_req_o, 1'b0);
        chk("post_rst_sck", sd_sck_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
